// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// slave = arbiter view, master = requesters + memory model view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    // Requesters hold *_req (and its operands) until their *_ack pulse.
    // The ack lasts one cycle and carries rdata/err with it.
    // Memory sees exactly one strobe per access. mem_ready completes the strobe
    // in the cycle it is sampled high.
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_ack;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic [3:0]        ls_be;
    logic [31:0]       ls_rdata;
    logic              ls_ack;

    logic              err;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ren;
    logic              mem_wen;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be,
               mem_rdata, mem_ready,
        output if_rdata, if_ack, ls_rdata, ls_ack, err,
               mem_addr, mem_wdata, mem_be, mem_ren, mem_wen
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be,
               mem_rdata, mem_ready,
        input  if_rdata, if_ack, ls_rdata, ls_ack, err,
               mem_addr, mem_wdata, mem_be, mem_ren, mem_wen
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store onto one memory port, with an access watchdog.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: LS over IF).
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output logic [1:0]   dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              grant_ls_q, grant_ls_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [7:0]        wdog_q, wdog_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;
    logic              err_q, err_d;
    logic              pick_ls;

`ifdef MEM_ARB_RR_EN
    logic last_grant_q, last_grant_d;  // 1 = LS won most recently

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_grant_q <= 1'b0;
        else     last_grant_q <= last_grant_d;
    end

    assign pick_ls      = bus.ls_req && (!bus.if_req || !last_grant_q);
    assign last_grant_d = (state_q == IDLE && (bus.if_req || bus.ls_req)) ? pick_ls : last_grant_q;
`else
    assign pick_ls = bus.ls_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_ls_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            wdog_q     <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_ls_q <= grant_ls_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            wdog_q     <= wdog_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_ls_d = grant_ls_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        wdog_d     = wdog_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.ls_req) begin
                    grant_ls_d = pick_ls;
                    wdog_d     = '0;
                    state_d    = ACCESS;
                    if (pick_ls) begin
                        addr_d  = bus.ls_addr;
                        we_d    = bus.ls_we;
                        wdata_d = bus.ls_wdata;
                        be_d    = bus.ls_we ? bus.ls_be : 4'hF;
                    end else begin
                        addr_d = bus.if_addr;
                        we_d   = 1'b0;
                        be_d   = 4'hF;
                    end
                end
            end
            ACCESS: begin
                wdog_d = wdog_q + 8'd1;
                // mem_ready wins over the watchdog when both land in the same cycle
                if (bus.mem_ready) begin
                    err_d   = 1'b0;
                    state_d = RESP;
                    if (!we_q) begin
                        if (grant_ls_q) ls_rdata_d = bus.mem_rdata;
                        else            if_rdata_d = bus.mem_rdata;
                    end
                end else if (wdog_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                    if (grant_ls_q) ls_rdata_d = '0;
                    else            if_rdata_d = '0;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_ren   = (state_q == ACCESS) && !we_q;
    assign bus.mem_wen   = (state_q == ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
    assign bus.if_ack    = (state_q == RESP) && !grant_ls_q;
    assign bus.ls_ack    = (state_q == RESP) && grant_ls_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.err       = err_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (default fixed-priority build).
// Scoreboard entries are {is_ls, err, rdata}, pushed at stimulus time and popped on ack.
module tb_mem_arbiter;
    localparam int ADDR_W = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    int         total = 0;
    int         bad = 0;
    logic [33:0] exp_q[$];
    logic [31:0] if_rdata_m;
    logic [31:0] ls_rdata_m;

    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus();

    mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // Plays the memory: answers the strobe after wait_n cycles (or never), records
    // the first-cycle strobe values and flags any later change. Returns at the ack.
    task automatic serve(input int wait_n, input bit respond, input logic [31:0] rdata,
                         input bit scramble, input int budget,
                         output bit acked, output int acc, output int ticks,
                         output logic [ADDR_W-1:0] s_addr, output logic [31:0] s_wdata,
                         output logic [3:0] s_be, output logic s_wen, output bit unstable);
        acked = 0; acc = 0; ticks = 0; unstable = 0;
        s_addr = '0; s_wdata = '0; s_be = '0; s_wen = 1'b0;
        while (!acked && ticks < budget) begin
            @(negedge clk);
            ticks++;
            if (bus.if_ack || bus.ls_ack) begin
                acked = 1;
                bus.mem_ready = 1'b0;
            end else if (bus.mem_ren || bus.mem_wen) begin
                acc++;
                if (bus.mem_ren && bus.mem_wen) unstable = 1;
                if (acc == 1) begin
                    s_addr = bus.mem_addr; s_wdata = bus.mem_wdata;
                    s_be = bus.mem_be; s_wen = bus.mem_wen;
                end else if (s_addr !== bus.mem_addr || s_wdata !== bus.mem_wdata ||
                             s_be !== bus.mem_be || s_wen !== bus.mem_wen) begin
                    unstable = 1;
                end
                if (scramble) begin
                    bus.if_addr = $urandom; bus.ls_addr = $urandom;
                    bus.ls_wdata = $urandom; bus.ls_be = 4'($urandom_range(0, 15));
                    bus.ls_we = 1'($urandom_range(0, 1));
                end
                bus.mem_ready = respond && (acc > wait_n);
                bus.mem_rdata = bus.mem_ren ? rdata : $urandom;
            end else begin
                bus.mem_ready = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (bus.if_ack !== 1'b0 || bus.ls_ack !== 1'b0 || bus.err !== 1'b0 ||
            bus.mem_ren !== 1'b0 || bus.mem_wen !== 1'b0 || bus.mem_addr !== '0 ||
            bus.mem_wdata !== '0 || bus.mem_be !== '0 || bus.if_rdata !== '0 ||
            bus.ls_rdata !== '0 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_outputs: state=%0d ren=%b wen=%b ack=%b%b addr=%h be=%h rdata=%h/%h, required all zero",
                     dbg_state, bus.mem_ren, bus.mem_wen, bus.if_ack, bus.ls_ack,
                     bus.mem_addr, bus.mem_be, bus.if_rdata, bus.ls_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (dbg_state !== 2'd0 || bus.mem_ren !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: state=%0d ren=%b, required 0 0", dbg_state, bus.mem_ren);
        end
    endtask

    task automatic test_if_read();
        bit acked, unst; int acc, tk;
        logic [ADDR_W-1:0] a; logic [31:0] wd; logic [3:0] be; logic wen;
        logic [33:0] want, got;
        bus.if_addr = 32'h100; bus.if_req = 1'b1;
        if_rdata_m = 32'h13;
        exp_q.push_back({1'b0, 1'b0, 32'h13});
        serve(0, 1'b1, 32'h13, 1'b0, 10, acked, acc, tk, a, wd, be, wen, unst);
        bus.if_req = 1'b0;
        total++;
        if (!acked || tk !== 2) begin
            bad++;
            $display("FAIL if_latency: acked=%0d ticks=%0d, required ack at tick 2", acked, tk);
        end
        total++;
        if (acc !== 1 || a !== 32'h100 || be !== 4'hF || wen !== 1'b0) begin
            bad++;
            $display("FAIL if_strobe: cycles=%0d addr=%h be=%h wen=%b, required 1 100 f 0", acc, a, be, wen);
        end
        got = {bus.ls_ack, bus.err, bus.ls_ack ? bus.ls_rdata : bus.if_rdata};
        want = exp_q.pop_front();
        total++;
        if (got !== want || bus.ls_rdata !== ls_rdata_m) begin
            bad++;
            $display("FAIL if_response: got=%h ls_rdata=%h, required %h ls_rdata=%h", got, bus.ls_rdata, want, ls_rdata_m);
        end
        @(negedge clk);
        total++;
        if (bus.if_ack !== 1'b0 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL if_ack_single: ack=%b state=%0d, required 0 0", bus.if_ack, dbg_state);
        end
    endtask

    task automatic test_store();
        bit acked, unst; int acc, tk;
        logic [ADDR_W-1:0] a; logic [31:0] wd; logic [3:0] be; logic wen;
        logic [33:0] want, got;
        bus.ls_addr = 32'h200; bus.ls_wdata = 32'hDEADBEEF; bus.ls_be = 4'b0011;
        bus.ls_we = 1'b1; bus.ls_req = 1'b1;
        exp_q.push_back({1'b1, 1'b0, ls_rdata_m});
        serve(3, 1'b1, 32'h0, 1'b1, 20, acked, acc, tk, a, wd, be, wen, unst);
        total++;
        if (!acked || acc !== 4 || unst) begin
            bad++;
            $display("FAIL store_hold: acked=%0d cycles=%0d unstable=%0d, required 1 4 0", acked, acc, unst);
        end
        total++;
        if (a !== 32'h200 || wd !== 32'hDEADBEEF || be !== 4'b0011 || wen !== 1'b1) begin
            bad++;
            $display("FAIL store_bus: addr=%h wdata=%h be=%h wen=%b, required 200 deadbeef 3 1", a, wd, be, wen);
        end
        got = {bus.ls_ack, bus.err, bus.ls_ack ? bus.ls_rdata : bus.if_rdata};
        want = exp_q.pop_front();
        total++;
        if (got !== want || bus.if_ack !== 1'b0 || bus.if_rdata !== if_rdata_m) begin
            bad++;
            $display("FAIL store_response: got=%h if_ack=%b if_rdata=%h, required %h 0 %h",
                     got, bus.if_ack, bus.if_rdata, want, if_rdata_m);
        end
        bus.ls_req = 1'b0; bus.ls_we = 1'b0;
    endtask

    task automatic test_priority();
        bit acked, unst; int acc, tk;
        logic [ADDR_W-1:0] a; logic [31:0] wd; logic [3:0] be; logic wen;
        logic [33:0] want, got;
        logic [31:0] r1, r2;
        r1 = $urandom; r2 = $urandom;
        bus.ls_addr = 32'h300; bus.ls_we = 1'b0; bus.ls_req = 1'b1;
        bus.if_addr = 32'h400; bus.if_req = 1'b1;
        ls_rdata_m = r1; exp_q.push_back({1'b1, 1'b0, r1});
        if_rdata_m = r2; exp_q.push_back({1'b0, 1'b0, r2});
        serve(1, 1'b1, r1, 1'b0, 10, acked, acc, tk, a, wd, be, wen, unst);
        got = {bus.ls_ack, bus.err, bus.ls_ack ? bus.ls_rdata : bus.if_rdata};
        want = exp_q.pop_front();
        total++;
        if (!acked || a !== 32'h300 || got !== want || bus.if_ack !== 1'b0) begin
            bad++;
            $display("FAIL prio_first: addr=%h got=%h if_ack=%b, required 300 %h 0", a, got, bus.if_ack, want);
        end
        bus.ls_req = 1'b0;
        serve(0, 1'b1, r2, 1'b0, 10, acked, acc, tk, a, wd, be, wen, unst);
        got = {bus.ls_ack, bus.err, bus.ls_ack ? bus.ls_rdata : bus.if_rdata};
        want = exp_q.pop_front();
        total++;
        if (!acked || a !== 32'h400 || got !== want || bus.ls_rdata !== ls_rdata_m) begin
            bad++;
            $display("FAIL prio_second: addr=%h got=%h ls_rdata=%h, required 400 %h %h", a, got, bus.ls_rdata, want, ls_rdata_m);
        end
        bus.if_req = 1'b0;
    endtask

    task automatic test_timeout();
        bit acked, unst; int acc, tk;
        logic [ADDR_W-1:0] a; logic [31:0] wd; logic [3:0] be; logic wen;
        logic [33:0] want, got;
        logic [31:0] r;
        bus.if_addr = 32'h500; bus.if_req = 1'b1;
        if_rdata_m = 32'h0; exp_q.push_back({1'b0, 1'b1, 32'h0});
        serve(0, 1'b0, 32'hFFFF_FFFF, 1'b0, 40, acked, acc, tk, a, wd, be, wen, unst);
        got = {bus.ls_ack, bus.err, bus.ls_ack ? bus.ls_rdata : bus.if_rdata};
        want = exp_q.pop_front();
        total++;
        if (!acked || acc !== 15) begin
            bad++;
            $display("FAIL timeout_cycles: acked=%0d cycles=%0d, required 1 15", acked, acc);
        end
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL timeout_response: got=%h, required %h", got, want);
        end
        r = $urandom;
        bus.if_addr = 32'h504;
        if_rdata_m = r; exp_q.push_back({1'b0, 1'b0, r});
        serve(2, 1'b1, r, 1'b0, 10, acked, acc, tk, a, wd, be, wen, unst);
        got = {bus.ls_ack, bus.err, bus.ls_ack ? bus.ls_rdata : bus.if_rdata};
        want = exp_q.pop_front();
        total++;
        if (!acked || acc !== 3 || a !== 32'h504 || got !== want) begin
            bad++;
            $display("FAIL after_timeout: cycles=%0d addr=%h got=%h, required 3 504 %h", acc, a, got, want);
        end
        bus.if_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int acks;
        bus.ls_addr = 32'h600; bus.ls_wdata = 32'h1234_5678; bus.ls_be = 4'hC;
        bus.ls_we = 1'b1; bus.ls_req = 1'b1; bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.mem_wen !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre: wen=%b, required 1", bus.mem_wen);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (bus.mem_wen !== 1'b0 || bus.mem_ren !== 1'b0 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL rst_async: wen=%b ren=%b state=%0d, required 0 0 0", bus.mem_wen, bus.mem_ren, dbg_state);
        end
        bus.ls_req = 1'b0; bus.ls_we = 1'b0;
        if_rdata_m = 32'h0; ls_rdata_m = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.if_ack || bus.ls_ack) acks++;
        end
        total++;
        if (acks !== 0 || dbg_state !== 2'd0 || bus.ls_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_no_ack: acks=%0d state=%0d ls_rdata=%h, required 0 0 0", acks, dbg_state, bus.ls_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int acks, last_ack, gap_bad;
        logic [31:0] r;
        logic [33:0] want, got;
        acks = 0; last_ack = -10; gap_bad = 0;
        bus.if_addr = 32'h700; bus.if_req = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            if (bus.if_ack || bus.ls_ack) begin
                acks++;
                if (acks > 1 && t - last_ack !== 3) gap_bad++;
                last_ack = t;
                bus.mem_ready = 1'b0;
                got = {bus.ls_ack, bus.err, bus.ls_ack ? bus.ls_rdata : bus.if_rdata};
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL b2b_response: tick=%0d got=%h, required %h", t, got, want);
                end
            end else if (bus.mem_ren || bus.mem_wen) begin
                r = $urandom;
                bus.mem_rdata = r; bus.mem_ready = 1'b1;
                if_rdata_m = r; exp_q.push_back({1'b0, 1'b0, r});
                bus.if_addr = $urandom;
            end else begin
                bus.mem_ready = 1'b0;
            end
        end
        bus.if_req = 1'b0; bus.mem_ready = 1'b0;
        total++;
        if (acks !== 10 || gap_bad !== 0) begin
            bad++;
            $display("FAIL b2b_rate: acks=%0d bad_gaps=%0d, required 10 0", acks, gap_bad);
        end
    endtask

    task automatic test_random();
        bit acked, unst; int acc, tk, who, wt;
        logic [ADDR_W-1:0] a, ad; logic [31:0] wd, r; logic [3:0] be, be_want; logic wen;
        logic [33:0] want, got;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            who = $urandom_range(0, 2);
            wt = $urandom_range(0, 4);
            ad = $urandom; r = $urandom;
            if (who == 0) begin
                bus.if_addr = ad; bus.if_req = 1'b1;
                if_rdata_m = r; exp_q.push_back({1'b0, 1'b0, r});
                be_want = 4'hF;
            end else begin
                bus.ls_addr = ad; bus.ls_we = (who == 2); bus.ls_wdata = $urandom;
                bus.ls_be = 4'($urandom_range(0, 15)); bus.ls_req = 1'b1;
                if (who == 1) ls_rdata_m = r;
                be_want = (who == 2) ? bus.ls_be : 4'hF;
                exp_q.push_back({1'b1, 1'b0, ls_rdata_m});
            end
            serve(wt, 1'b1, r, 1'b1, 20, acked, acc, tk, a, wd, be, wen, unst);
            bus.if_req = 1'b0; bus.ls_req = 1'b0;
            got = {bus.ls_ack, bus.err, bus.ls_ack ? bus.ls_rdata : bus.if_rdata};
            want = exp_q.pop_front();
            total++;
            if (!acked || acc !== wt + 1 || a !== ad || be !== be_want || wen !== (who == 2) ||
                unst || got !== want) begin
                bad++;
                $display("FAIL random_%0d: who=%0d cycles=%0d addr=%h be=%h wen=%b unstable=%0d got=%h, required cycles=%0d addr=%h be=%h got=%h",
                         i, who, acc, a, be, wen, unst, got, wt + 1, ad, be_want, want);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0;
        bus.ls_wdata = '0; bus.ls_be = '0;
        bus.mem_rdata = '0; bus.mem_ready = 1'b0;
        if_rdata_m = '0; ls_rdata_m = '0;
        test_reset();
        test_if_read();
        test_store();
        test_priority();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain: left=%0d, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the CPU's single memory port between two requesters: instruction fetch (IF) and load/store (LS).
- Registers the winning request, drives one memory access, waits for mem_ready, then returns read data and a one-cycle ack to the granted requester.
- Includes a watchdog that terminates accesses that never complete.
- Sits between the fetch/exec stages and the top-level memory interface (addr, data_out, mem_ren, mem_wen).

Parameters:
- ADDR_W, 32, address width for all address ports.
- TIMEOUT, 15, cycles spent in ACCESS without mem_ready before the access is aborted with error; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  32  fetch read data, valid while if_ack=1
- if_ack  out  1  one-cycle completion pulse for fetch
- ls_req  in  1  load/store request; held until ls_ack
- ls_we  in  1  1=store, 0=load
- ls_addr  in  ADDR_W  load/store address
- ls_wdata  in  32  store data
- ls_be  in  4  store byte enables
- ls_rdata  out  32  load data, valid while ls_ack=1
- ls_ack  out  1  one-cycle completion pulse for load/store
- err  out  1  valid with an ack; 1 = access timed out
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_be  out  4  memory byte enables (4'hF on reads)
- mem_ren  out  1  read strobe
- mem_wen  out  1  write strobe
- mem_rdata  in  32  memory read data, sampled when mem_ready=1
- mem_ready  in  1  memory completion for the current strobe

Behaviour:
- Reset (async) forces state IDLE and clears all outputs: acks, err, mem_ren, mem_wen, mem_addr, mem_wdata, mem_be, if_rdata, ls_rdata, the watchdog counter and last_grant (last_grant=IF).
- Reset mid-access abandons the access immediately; no ack is issued after reset release.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Stays in IDLE if neither request is high.
  - Otherwise selects a winner; default fixed priority is LS over IF.
  - Latches the winner's address; for LS also latches we/wdata/be. For IF, or an LS read, mem_be=4'hF.
  - Records grant = winner, clears the watchdog, and moves to ACCESS.
- ACCESS:
  - Drives mem_ren = !we or mem_wen = we from the latched values; exactly one strobe is high and all memory outputs are stable.
  - Watchdog increments every cycle.
  - If mem_ready=1: capture mem_rdata (reads only), set err=0, go to RESP.
  - Else if watchdog == TIMEOUT-1: set err=1 and capture rdata=0, go to RESP.
  - mem_ready takes precedence over timeout in the same cycle.
- RESP:
  - Strobes are low.
  - The ack of the granted requester is 1 for exactly one cycle; rdata of the granted requester holds the captured value and err holds its value.
  - Next state is IDLE.
- Latency: request seen at edge N → strobe high in cycle N+1 → if mem_ready in that cycle, ack in cycle N+2. Minimum 3 cycles from request to the next grant decision.
- Requesters must deassert req in the cycle following ack, or keep it high for a new access; IDLE re-arbitrates every time.
- Request dropped mid-ACCESS: the access still completes and the ack is still pulsed.
- Changes to address/data inputs after the grant are ignored.
- The non-granted requester's ack stays 0. if_rdata/ls_rdata hold their last value except when updated for their own grant.
- mem_ready while in IDLE or RESP is ignored.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both requests are high in IDLE, grant goes to the requester that is not last_grant. last_grant updates on every grant. A single request is granted directly.
- Undefined: fixed priority LS > IF; last_grant is not implemented.

Test Plan:
- IF only, if_addr=0x100, mem_ready=1 on first ACCESS cycle, mem_rdata=0x00000013 → mem_ren high 1 cycle with mem_addr=0x100, mem_be=F; if_ack at N+2 with if_rdata=0x13, err=0.
- LS store: addr=0x200, wdata=0xDEADBEEF, be=4'b0011, mem_ready after 3 wait cycles → mem_wen held 4 cycles with stable values; ls_ack once; if_ack=0.
- Both requests high at the same edge, fixed priority → LS granted first, IF second. With MEM_ARB_RR_EN and last_grant=LS → IF granted first.
- mem_ready never asserted, TIMEOUT=15 → exactly 15 ACCESS cycles, then ack with err=1 and rdata=0; next request proceeds normally.
- rst asserted during the 2nd ACCESS cycle → strobes drop asynchronously; no ack after release; state IDLE.
- if_req held high continuously with mem_ready=1 → one access every 3 cycles, ack pulses never adjacent.
